loop_gain_scheduler: RTL and testbench

Sequences the symbol-sync loop filter between a wide-band acquisition mode and a narrow-band tracking mode. It accepts timing-error samples at symbol strobes and forwards them to the loop filter with a valid strobe. It measures the error magnitude over fixed windows and selects the filter coefficients (c1, c2) and lock status from that measurement. It sits between the timing error detector and the loop filter.

---
 rtl/loop_gain_scheduler.sv | 104 ++++++++++
 tb/tb_loop_gain_scheduler.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/loop_gain_scheduler.sv
// loop_gain_scheduler: forwards timing-error samples to the loop filter and
// switches gains between acquisition and tracking from windowed |err| sums.
module loop_gain_scheduler #(
  parameter int DW = 16,
  parameter int WIN_LOG2 = 4,
  parameter logic [DW-1:0] C1_ACQ = 16'h0106,
  parameter logic [DW-1:0] C2_ACQ = 16'h0246,
  parameter logic [DW-1:0] C1_TRK = 16'h0041,
  parameter logic [DW-1:0] C2_TRK = 16'h0091,
  parameter logic [DW+WIN_LOG2-1:0] LOCK_TH = 'h1000,
  parameter logic [DW+WIN_LOG2-1:0] UNLOCK_TH = 'h4000,
  parameter int ACQ_MIN = 4,
  parameter int LOCK_CNT = 2,
  parameter int UNLOCK_CNT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          mk,
  input  logic          err_valid,
  input  logic [DW-1:0] err_in,
  output logic          f_valid,
  output logic [DW-1:0] f_err,
  output logic          f_clr,
  output logic [DW-1:0] c1,
  output logic [DW-1:0] c2,
  output logic          locked,
  output logic [1:0]    state
);
  typedef enum logic [1:0] {IDLE = 2'b00, ACQ = 2'b01, TRK = 2'b10} st_t;
  st_t st;
  logic [DW+WIN_LOG2-1:0] acc_sum, sum;
  logic [WIN_LOG2-1:0] cnt;
  logic [7:0] wins, goods, bads, wins_n, goods_n, bads_n;
  logic [DW-1:0] mag;
  logic acc, last, good, bad;
  assign state = st;
  // Most negative input saturates so the magnitude still fits in DW-1 bits
  always_comb begin
    acc = err_valid & mk & (st != IDLE);
    mag = !err_in[DW-1] ? err_in :
          (err_in == {1'b1, {(DW-1){1'b0}}}) ? {1'b0, {(DW-1){1'b1}}} : -err_in;
    sum = acc_sum + (DW+WIN_LOG2)'(mag);
    last = acc & (&cnt);
    good = sum < LOCK_TH;
    bad = sum > UNLOCK_TH;
    wins_n = (wins >= 8'(ACQ_MIN)) ? wins : wins + 8'd1;
    goods_n = good ? goods + 8'd1 : 8'd0;
    bads_n = bad ? bads + 8'd1 : 8'd0;
  end
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      st <= IDLE;
      c1 <= C1_ACQ;
      c2 <= C2_ACQ;
      locked <= 1'b0;
      f_valid <= 1'b0;
      f_clr <= 1'b0;
      acc_sum <= '0;
      cnt <= '0;
      wins <= '0;
      goods <= '0;
      bads <= '0;
      if (rst) f_err <= '0;
    end else begin
      f_valid <= acc;
      f_clr <= 1'b0;
      if (acc) begin
        f_err <= err_in;
        acc_sum <= last ? '0 : sum;
        cnt <= cnt + 1'b1;
      end
      if (st == IDLE) begin
        st <= ACQ;
        f_clr <= 1'b1;
      end else if (last && st == ACQ) begin
        wins <= wins_n;
        goods <= goods_n;
        // Lock keeps the integrator: no clear pulse on ACQ->TRK
        if (wins_n >= 8'(ACQ_MIN) && goods_n >= 8'(LOCK_CNT)) begin
          st <= TRK;
          c1 <= C1_TRK;
          c2 <= C2_TRK;
          locked <= 1'b1;
          wins <= '0;
          goods <= '0;
          bads <= '0;
        end
      end else if (last && st == TRK) begin
        bads <= bads_n;
        if (bads_n >= 8'(UNLOCK_CNT)) begin
          st <= ACQ;
          f_clr <= 1'b1;
          c1 <= C1_ACQ;
          c2 <= C2_ACQ;
          locked <= 1'b0;
          wins <= '0;
          goods <= '0;
          bads <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_loop_gain_scheduler.sv
// tb_loop_gain_scheduler: directed stimulus against a window-sum reference model
// compared every cycle, plus hand-computed literal checkpoints.
module tb_loop_gain_scheduler;
  logic clk = 0, rst = 1, en = 0, mk = 0, err_valid = 0;
  logic [15:0] err_in = '0;
  logic f_valid, f_clr, locked;
  logic [15:0] f_err, c1, c2;
  logic [1:0] state;
  int checks = 0, errors = 0;
  // reference model state
  int m_state = 0, m_locked = 0, m_fv = 0, m_fclr = 0, m_ferr = 0;
  int m_c1 = 'h0106, m_c2 = 'h0246;
  int win_sum = 0, n_samp = 0, n_win = 0, n_good = 0, n_bad = 0;

  loop_gain_scheduler dut (
    .clk(clk), .rst(rst), .en(en), .mk(mk), .err_valid(err_valid), .err_in(err_in),
    .f_valid(f_valid), .f_err(f_err), .f_clr(f_clr), .c1(c1), .c2(c2),
    .locked(locked), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_acq();
    m_c1 = 'h0106; m_c2 = 'h0246; m_locked = 0;
  endtask

  task automatic clear_windows();
    win_sum = 0; n_samp = 0; n_win = 0; n_good = 0; n_bad = 0;
  endtask

  always @(posedge clk) begin
    int mag, v;
    bit a, g, b;
    if (rst) begin
      m_state = 0; m_fv = 0; m_fclr = 0; m_ferr = 0; set_acq(); clear_windows();
    end else if (!en) begin
      m_state = 0; m_fv = 0; m_fclr = 0; set_acq(); clear_windows();
    end else begin
      a = err_valid && mk && m_state != 0;
      m_fclr = 0;
      m_fv = a;
      if (a) m_ferr = err_in;
      if (m_state == 0) begin
        m_state = 1; m_fclr = 1;
      end else if (a) begin
        v = $signed(err_in);
        mag = (v < 0) ? -v : v;
        if (mag > 32767) mag = 32767;
        win_sum += mag;
        n_samp++;
        if (n_samp == 16) begin
          g = win_sum < 'h1000;
          b = win_sum > 'h4000;
          win_sum = 0; n_samp = 0;
          if (m_state == 1) begin
            n_win++;
            n_good = g ? n_good + 1 : 0;
            if (n_win >= 4 && n_good >= 2) begin
              m_state = 2; m_c1 = 'h0041; m_c2 = 'h0091; m_locked = 1; clear_windows();
            end
          end else begin
            n_bad = b ? n_bad + 1 : 0;
            if (n_bad >= 3) begin
              m_state = 1; m_fclr = 1; set_acq(); clear_windows();
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("state", state, m_state);
    chk("locked", locked, m_locked);
    chk("f_valid", f_valid, m_fv);
    chk("f_clr", f_clr, m_fclr);
    chk("f_err", f_err, m_ferr);
    chk("c1", c1, m_c1);
    chk("c2", c2, m_c2);
  end

  task automatic drive(input bit e, input bit m, input bit v, input logic [15:0] d);
    en = e; mk = m; err_valid = v; err_in = d;
    @(negedge clk);
  endtask

  task automatic feed(input int n, input logic [15:0] d);
    for (int i = 0; i < n; i++) drive(1, 1, 1, d);
  endtask

  initial begin
    drive(0, 0, 0, 16'h0);
    drive(0, 0, 0, 16'h0);
    rst = 0;
    for (int i = 0; i < 4; i++) drive(0, 1, 1, 16'h0010);
    chk("idle_state", state, 0);
    chk("idle_fvalid", f_valid, 0);
    chk("idle_c1", c1, 'h0106);
    chk("idle_c2", c2, 'h0246);
    chk("idle_fclr", f_clr, 0);
    // acquire: IDLE cycle sample is ignored, then 64 accepted samples lock
    drive(1, 1, 1, 16'h0010);
    chk("en_fclr", f_clr, 1);
    chk("en_state", state, 1);
    chk("en_fvalid", f_valid, 0);
    feed(1, 16'h0010);
    chk("lat1_fvalid", f_valid, 1);
    chk("lat1_ferr", f_err, 'h0010);
    feed(62, 16'h0010);
    chk("pre_lock_state", state, 1);
    feed(1, 16'h0010);
    chk("lock_state", state, 2);
    chk("lock_locked", locked, 1);
    chk("lock_c1", c1, 'h0041);
    chk("lock_c2", c2, 'h0091);
    chk("lock_fclr", f_clr, 0);
    // unlock: bad, saturated bad, good resets count, then three bad windows
    feed(16, 16'hFB00);
    feed(16, 16'h8000);
    feed(16, 16'h0010);
    feed(16, 16'hFB00);
    feed(16, 16'h8000);
    feed(15, 16'hFB00);
    chk("pre_unlock_state", state, 2);
    feed(1, 16'hFB00);
    chk("unlock_state", state, 1);
    chk("unlock_fclr", f_clr, 1);
    chk("unlock_locked", locked, 0);
    chk("unlock_c1", c1, 'h0106);
    // lock delay: three neutral windows then two good ones
    feed(48, 16'h0300);
    feed(16, 16'h0010);
    chk("delay_w4_state", state, 1);
    feed(15, 16'h0010);
    chk("delay_w5m_state", state, 1);
    feed(1, 16'h0010);
    chk("delay_lock_state", state, 2);
    // en drop from TRK, then mid-window in ACQ
    drive(0, 1, 1, 16'h0010);
    chk("drop_state", state, 0);
    chk("drop_fclr", f_clr, 0);
    drive(1, 1, 1, 16'h0010);
    chk("reen_fclr", f_clr, 1);
    feed(7, 16'h0010);
    drive(0, 1, 1, 16'h0010);
    chk("drop2_state", state, 0);
    chk("drop2_fclr", f_clr, 0);
    chk("drop2_fvalid", f_valid, 0);
    chk("drop2_c1", c1, 'h0106);
    drive(1, 1, 1, 16'h0010);
    chk("reen2_fclr", f_clr, 1);
    feed(30, 16'h0010);
    drive(1, 1, 0, 16'h0010);
    chk("mk_only_fvalid", f_valid, 0);
    drive(1, 0, 1, 16'h0010);
    feed(33, 16'h0010);
    chk("fresh_pre_state", state, 1);
    feed(1, 16'h0010);
    chk("fresh_lock_state", state, 2);
    drive(0, 0, 0, 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
